// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM multicycle control unit.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam int unsigned ALU_W  = 3;
  localparam int unsigned COND_W = 4;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_ORR = 3'b011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register with per-group write masking and condition-field evaluation.
module cond_unit
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COND_W-1:0] cond,
  input  logic [3:0]        alu_flags,
  input  logic [1:0]        flag_write,
  output logic [3:0]        nzcv,
  output logic              condex
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // flag_write[1] covers N/Z, flag_write[0] covers C/V
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv <= FLAG_RESET;
    end else begin
      if (flag_write[1]) nzcv[3:2] <= alu_flags[3:2];
      if (flag_write[0]) nzcv[1:0] <= alu_flags[1:0];
    end
  end

  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control FSM with NZCV/condition handling.
// Define MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module arm_multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic [3:0]       ALUFlags,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [ALU_W-1:0] ALUControl,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic             RegWrite
);

  state_t state, state_n;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       condex, condex_q;
  logic       mem_go;
  logic       pcw, memw, irw, regw;
  logic [ALU_W-1:0] alu_dp;
  logic       nowrite, logical;
  logic [1:0] flag_write;
  logic [3:0] nzcv;

  assign op     = Instr[27:26];
  assign cmd    = Instr[24:21];
  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

`ifdef MEM_WAIT_EN
  assign mem_go = mem_ready;
  logic unused_bits;
  assign unused_bits = ^Instr[19:0];
`else
  assign mem_go = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{Instr[19:0], mem_ready};
`endif

  always_comb begin
    alu_dp  = ALU_ADD;
    nowrite = 1'b0;
    logical = 1'b0;
    case (cmd)
      CMD_ADD: alu_dp = ALU_ADD;
      CMD_SUB: alu_dp = ALU_SUB;
      CMD_CMP: begin alu_dp = ALU_SUB; nowrite = 1'b1; end
      CMD_AND: begin alu_dp = ALU_AND; logical = 1'b1; end
      CMD_ORR: begin alu_dp = ALU_ORR; logical = 1'b1; end
      default: nowrite = 1'b1;
    endcase
  end

  // Condition is frozen at DECODE so an instruction never sees its own flag update
  assign flag_write = ((state == EXECR || state == EXECI) && Instr[20] && condex_q)
                      ? {1'b1, ~logical} : 2'b00;

  cond_unit #(.FLAG_RESET(FLAG_RESET)) u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (Instr[31:28]),
    .alu_flags  (ALUFlags),
    .flag_write (flag_write),
    .nzcv       (nzcv),
    .condex     (condex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      condex_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE) condex_q <= condex;
    end
  end

  always_comb begin
    state_n    = state;
    pcw        = 1'b0;
    AdrSrc     = 1'b0;
    memw       = 1'b0;
    irw        = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    regw       = 1'b0;
    case (state)
      FETCH: begin
        irw       = mem_go;
        pcw       = mem_go;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_go) state_n = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        case (op)
          2'b00:   state_n = Instr[25] ? EXECI : EXECR;
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          default: state_n = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_n = Instr[20] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_go) state_n = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_READDATA;
        regw      = condex_q;
        state_n   = FETCH;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        memw   = condex_q;
        if (mem_go) state_n = FETCH;
      end
      EXECR: begin
        ALUControl = alu_dp;
        state_n    = ALUWB;
      end
      EXECI: begin
        ALUControl = alu_dp;
        ALUSrcB    = SRCB_IMM;
        state_n    = ALUWB;
      end
      ALUWB: begin
        regw    = condex_q & ~nowrite;
        state_n = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pcw       = condex_q;
        state_n   = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  assign PCWrite  = pcw  & ~reset;
  assign MemWrite = memw & ~reset;
  assign IRWrite  = irw  & ~reset;
  assign RegWrite = regw & ~reset;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Self-checking bench: instruction table replayed cycle by cycle through a scoreboard.
module tb_arm_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;

  always #5 clk = ~clk;

  arm_multicycle_controller #(.FLAG_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite)
  );

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MB = 4,
                 S_MW = 5, S_ER = 6, S_EI = 7, S_AW = 8, S_BR = 9;
  localparam int K_DPR = 0, K_DPI = 1, K_LDR = 2, K_STR = 3, K_B = 4, K_NOP = 5;

  int seqs [6][5] = '{
    '{S_F, S_D, S_ER, S_AW, S_F},
    '{S_F, S_D, S_EI, S_AW, S_F},
    '{S_F, S_D, S_MA, S_MR, S_MB},
    '{S_F, S_D, S_MA, S_MW, S_F},
    '{S_F, S_D, S_BR, S_F,  S_F},
    '{S_F, S_D, S_F,  S_F,  S_F}
  };
  int lens [6] = '{4, 4, 5, 4, 3, 2};

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [2:0]  kind;
    logic [2:0]  alu;
    logic        pass;
    logic        nowr;
    logic [1:0]  regsrc;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t        tv [24];
  int          ntv;
  logic [16:0] sb_q [$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [3:0] f, input int k,
                              input logic [2:0] a, input logic p, input logic nw,
                              input logic [1:0] rs, input logic [3:0] nz);
    vec_t v;
    v.instr = i; v.flags = f; v.kind = 3'(k); v.alu = a; v.pass = p;
    v.nowr = nw; v.regsrc = rs; v.nzcv = nz;
    return v;
  endfunction

  // Expected outputs for one state, from the per-state output table
  function automatic logic [16:0] exp_vec(input int st, input vec_t v, input logic ready);
    logic pcw, adr, mw, irw, sa, rw;
    logic [1:0] rs, sbv;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; sa = 0; rw = 0; rs = 2'b00; sbv = 2'b00; alu = 3'b000;
    case (st)
      S_F:  begin pcw = ready; irw = ready; rs = 2'b10; sa = 1; sbv = 2'b10; end
      S_D:  begin sa = 1; sbv = 2'b10; end
      S_MA: sbv = 2'b01;
      S_MR: adr = 1;
      S_MB: begin rs = 2'b01; rw = v.pass; end
      S_MW: begin adr = 1; mw = v.pass; end
      S_ER: alu = v.alu;
      S_EI: begin alu = v.alu; sbv = 2'b01; end
      S_AW: rw = v.pass & ~v.nowr;
      S_BR: begin sbv = 2'b01; rs = 2'b10; pcw = v.pass; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, alu, sa, sbv, rw, v.instr[27:26], v.regsrc};
  endfunction

  function automatic logic [16:0] act_vec();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
            ALUSrcA, ALUSrcB, RegWrite, ImmSrc, RegSrc};
  endfunction

  task automatic step_check(input string name, input logic [16:0] e);
    logic [16:0] got;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    chk(name, 32'(act_vec()), 32'(got));
    @(posedge clk); #1;
  endtask

  task automatic run(input int idx);
    vec_t v;
    v = tv[idx];
    Instr = v.instr;
    ALUFlags = v.flags;
    for (int c = 0; c < lens[int'(v.kind)]; c++)
      step_check($sformatf("vec%0d_cyc%0d", idx, c), exp_vec(seqs[int'(v.kind)][c], v, 1'b1));
    chk($sformatf("vec%0d_nzcv", idx), 32'(dut.u_cond.nzcv), 32'(v.nzcv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    ntv = 0;
    tv[ntv++] = mk(32'hE0821003, 4'b1111, K_DPR, 3'b000, 1, 0, 2'b00, 4'b0000); // ADD
    tv[ntv++] = mk(32'hE1510002, 4'b0100, K_DPR, 3'b001, 1, 1, 2'b00, 4'b0100); // CMP
    tv[ntv++] = mk(32'h0A000002, 4'b0000, K_B,   3'b000, 1, 0, 2'b01, 4'b0100); // BEQ taken
    tv[ntv++] = mk(32'hE0921003, 4'b0000, K_DPR, 3'b000, 1, 0, 2'b00, 4'b0000); // ADDS
    tv[ntv++] = mk(32'h0A000002, 4'b1111, K_B,   3'b000, 0, 0, 2'b01, 4'b0000); // BEQ not taken
    tv[ntv++] = mk(32'hE5921004, 4'b0000, K_LDR, 3'b000, 1, 0, 2'b10, 4'b0000); // LDR
    tv[ntv++] = mk(32'hE5821004, 4'b0000, K_STR, 3'b000, 1, 0, 2'b10, 4'b0000); // STR
    tv[ntv++] = mk(32'hE0521003, 4'b0011, K_DPR, 3'b001, 1, 0, 2'b00, 4'b0011); // SUBS
    tv[ntv++] = mk(32'hE2121003, 4'b1000, K_DPI, 3'b010, 1, 0, 2'b00, 4'b1011); // ANDS imm, C/V held
    tv[ntv++] = mk(32'hE1921003, 4'b0100, K_DPR, 3'b011, 1, 0, 2'b00, 4'b0111); // ORRS, C/V held
    tv[ntv++] = mk(32'h10921003, 4'b1000, K_DPR, 3'b000, 0, 0, 2'b00, 4'b0111); // ADDNES fails
    tv[ntv++] = mk(32'hEC000000, 4'b0000, K_NOP, 3'b000, 1, 0, 2'b00, 4'b0111); // op=11
    tv[ntv++] = mk(32'hF0821003, 4'b0000, K_DPR, 3'b000, 0, 0, 2'b00, 4'b0111); // cond 1111
    tv[ntv++] = mk(32'hE0621003, 4'b0000, K_DPR, 3'b000, 1, 1, 2'b00, 4'b0111); // unknown cmd
    tv[ntv++] = mk(32'hCA000002, 4'b0000, K_B,   3'b000, 0, 0, 2'b01, 4'b0111); // BGT
    tv[ntv++] = mk(32'hDA000002, 4'b0000, K_B,   3'b000, 1, 0, 2'b01, 4'b0111); // BLE
    tv[ntv++] = mk(32'h2A000002, 4'b0000, K_B,   3'b000, 1, 0, 2'b01, 4'b0111); // BCS
    tv[ntv++] = mk(32'h4A000002, 4'b0000, K_B,   3'b000, 0, 0, 2'b01, 4'b0111); // BMI
    tv[ntv++] = mk(32'hBA000002, 4'b0000, K_B,   3'b000, 1, 0, 2'b01, 4'b0111); // BLT
    tv[ntv++] = mk(32'h8A000002, 4'b0000, K_B,   3'b000, 0, 0, 2'b01, 4'b0111); // BHI
    tv[ntv++] = mk(32'h15921004, 4'b0000, K_LDR, 3'b000, 0, 0, 2'b10, 4'b0111); // LDRNE fails
    tv[ntv++] = mk(32'h05821004, 4'b0000, K_STR, 3'b000, 1, 0, 2'b10, 4'b0111); // STREQ

    reset = 1'b1; Instr = 32'h0; ALUFlags = 4'b0000; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_we_c1", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_we_c2", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_nzcv", 32'(dut.u_cond.nzcv), 32'h0);

    for (int i = 0; i < ntv; i++) run(i);

`ifdef MEM_WAIT_EN
    // FETCH stalled three cycles, then NOP completes
    v = mk(32'hEC000000, 4'b0000, K_NOP, 3'b000, 1, 0, 2'b00, 4'b0111);
    Instr = v.instr;
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) step_check($sformatf("wait_fetch%0d", c), exp_vec(S_F, v, 1'b0));
    mem_ready = 1'b1;
    step_check("wait_fetch_go", exp_vec(S_F, v, 1'b1));
    step_check("wait_decode", exp_vec(S_D, v, 1'b1));
    // STR held two cycles in MEMWR keeps MemWrite high
    v = mk(32'hE5821004, 4'b0000, K_STR, 3'b000, 1, 0, 2'b10, 4'b0111);
    Instr = v.instr;
    step_check("wstr_f", exp_vec(S_F, v, 1'b1));
    step_check("wstr_d", exp_vec(S_D, v, 1'b1));
    step_check("wstr_ma", exp_vec(S_MA, v, 1'b1));
    mem_ready = 1'b0;
    step_check("wstr_mw0", exp_vec(S_MW, v, 1'b1));
    step_check("wstr_mw1", exp_vec(S_MW, v, 1'b1));
    mem_ready = 1'b1;
    step_check("wstr_mw2", exp_vec(S_MW, v, 1'b1));
`endif

    // Reset asserted while in MEMRD
    v = mk(32'hE5921004, 4'b0000, K_LDR, 3'b000, 1, 0, 2'b10, 4'b0111);
    Instr = v.instr;
    step_check("rst_ldr_f", exp_vec(S_F, v, 1'b1));
    step_check("rst_ldr_d", exp_vec(S_D, v, 1'b1));
    step_check("rst_ldr_ma", exp_vec(S_MA, v, 1'b1));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_memrd_we", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    v.regsrc = 2'b10;
    step_check("rst_after_fetch", exp_vec(S_F, v, 1'b1));
    chk("rst_after_nzcv", 32'(dut.u_cond.nzcv), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
